// File: rtl/dstack_ctl.sv
// Forth data-stack controller: T and N held in registers, deeper cells spilled
// to / refilled from an external memory stack, one stack op per cycle.
module dstack_ctl #(
    parameter int DSZ   = 32,
    parameter int DEPTH = 64,
    parameter int SSZ   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [DSZ-1:0]   lit,
    output logic [DSZ-1:0]   tos,
    output logic [DSZ-1:0]   nos,
    output logic [SSZ+1:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             err,
    output logic             ss_push,
    output logic             ss_pop,
    output logic [DSZ-1:0]   ss_vi,
    input  logic [DSZ-1:0]   ss_vo,
    input  logic [SSZ-1:0]   ss_idx
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_DROP = 3'd2,
        OP_DUP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_OVER = 3'd5,
        OP_ROT  = 3'd6,
        OP_ADD  = 3'd7
    } op_e;

    localparam logic [SSZ+1:0] MAXD = (SSZ+2)'(DEPTH + 2);
    localparam logic [SSZ+1:0] ONE  = (SSZ+2)'(1);

    logic [DSZ-1:0] r_t, r_n;
    logic [SSZ+1:0] r_depth;
    logic           r_err;

    logic           w_d1, w_d2, w_d3, w_nf;
    logic           w_ok, w_push, w_pop, w_go, w_rej;
    logic [DSZ-1:0] w_t, w_n;
    logic [SSZ+1:0] w_dn;
    logic           w_unused;

    // The memory keeps its own pointer; depth here is the authority.
    assign w_unused = ^ss_idx;

    assign w_d1 = (r_depth != '0);
    assign w_d2 = (r_depth >= (SSZ+2)'(2));
    assign w_d3 = (r_depth >= (SSZ+2)'(3));
    assign w_nf = (r_depth != MAXD);

    always_comb begin
        w_ok   = 1'b1;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_t    = r_t;
        w_n    = r_n;
        w_dn   = r_depth;
        case (op_e'(op))
            OP_PUSH: begin
                w_ok   = w_nf;
                w_t    = lit;
                w_n    = r_t;
                w_push = w_d2;
                w_dn   = r_depth + ONE;
            end
            OP_DROP: begin
                w_ok  = w_d1;
                w_t   = r_n;
                w_n   = w_d3 ? ss_vo : '0;
                w_pop = w_d3;
                w_dn  = r_depth - ONE;
            end
            OP_DUP: begin
                w_ok   = w_d1 & w_nf;
                w_n    = r_t;
                w_push = w_d2;
                w_dn   = r_depth + ONE;
            end
            OP_SWAP: begin
                w_ok = w_d2;
                w_t  = r_n;
                w_n  = r_t;
            end
            OP_OVER: begin
                w_ok   = w_d2 & w_nf;
                w_t    = r_n;
                w_n    = r_t;
                w_push = 1'b1;
                w_dn   = r_depth + ONE;
            end
            OP_ROT: begin
                // Push+pop together overwrites memory top with old N.
                w_ok   = w_d3;
                w_t    = ss_vo;
                w_n    = r_t;
                w_push = 1'b1;
                w_pop  = 1'b1;
            end
            OP_ADD: begin
                w_ok  = w_d2;
                w_t   = r_n + r_t;
                w_n   = w_d3 ? ss_vo : '0;
                w_pop = w_d3;
                w_dn  = r_depth - ONE;
            end
            default: ;
        endcase
    end

    assign op_ready = ~rst;
    assign w_go     = op_valid & op_ready & w_ok;
    assign w_rej    = op_valid & op_ready & ~w_ok;
    assign ss_push  = w_go & w_push;
    assign ss_pop   = w_go & w_pop;
    assign ss_vi    = r_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t     <= '0;
            r_n     <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_rej;
            if (w_go) begin
                r_t     <= w_t;
                r_n     <= w_n;
                r_depth <= w_dn;
            end
        end
    end

    assign tos   = r_t;
    assign nos   = r_n;
    assign depth = r_depth;
    assign err   = r_err;
    assign empty = (r_depth == '0);
    assign full  = (r_depth == MAXD);

endmodule
